// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage load/store unit.
// FSM states, CU load/store option encodings and an alignment helper.
package mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        RD,
        WR,
        DONE
    } state_t;

    localparam int LD_BYTE = 0;
    localparam int LD_HALF = 1;
    localparam int LD_SIGN = 2;

    localparam logic [1:0] SV_WORD = 2'b00;
    localparam logic [1:0] SV_BYTE = 2'b01;
    localparam logic [1:0] SV_HALF = 2'b10;

    function automatic logic misaligned(
        input logic       half,
        input logic       word,
        input logic [1:0] lane
    );
        return (half && lane[0]) || (word && (lane != 2'b00));
    endfunction

endpackage

// File: rtl/lane_align.sv
// Byte-lane extraction with sign/zero extension for loads and
// sub-word merge of store data into an old memory word.
module lane_align
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [2:0]  load_option,
    input  logic [31:0] wdata,
    input  logic [1:0]  save_option,
    output logic [31:0] ld_data,
    output logic [31:0] st_data
);

    logic [7:0]  ld_b;
    logic [15:0] ld_h;
    logic        sgn;

    always_comb begin
        ld_b    = word[{lane, 3'b000} +: 8];
        ld_h    = lane[1] ? word[31:16] : word[15:0];
        sgn     = load_option[LD_SIGN];
        ld_data = word;
        unique case (1'b1)
            !load_option[LD_BYTE]:
                ld_data = word;
            load_option[LD_BYTE] && load_option[LD_HALF]:
                ld_data = {{16{sgn & ld_h[15]}}, ld_h};
            load_option[LD_BYTE] && !load_option[LD_HALF]:
                ld_data = {{24{sgn & ld_b[7]}}, ld_b};
            default:
                ld_data = word;
        endcase
    end

    always_comb begin
        st_data = wdata;
        unique case (save_option)
            SV_BYTE: begin
                st_data = word;
                st_data[{lane, 3'b000} +: 8] = wdata[7:0];
            end
            SV_HALF: begin
                st_data = word;
                st_data[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: st_data = wdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit on a word-only bus; sub-word stores
// are done as read-modify-write. All outputs are registered.
module mem_access_unit
    import mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        mem_write,
    input  logic        mem_read,
    input  logic [2:0]  load_option,
    input  logic [1:0]  save_option,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        align_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    state_t      state, state_n;
    logic [1:0]  lane_q;
    logic [31:0] wdata_q;
    logic        we_q, re_q;
    logic [2:0]  ld_q;
    logic [1:0]  sv_q;
    logic        acked, mis, accept;
    logic [31:0] ld_word, st_word;

    lane_align u_align (
        .word        (bus_rdata),
        .lane        (lane_q),
        .load_option (ld_q),
        .wdata       (wdata_q),
        .save_option (sv_q),
        .ld_data     (ld_word),
        .st_data     (st_word)
    );

    assign acked  = bus_req && bus_ack;
    assign accept = (state == IDLE) && start;

    always_comb begin
        mis = 1'b0;
        if (we_q)
            mis = misaligned(sv_q == SV_HALF, sv_q == SV_WORD, lane_q);
        else if (re_q)
            mis = misaligned(ld_q[LD_BYTE] && ld_q[LD_HALF],
                             !ld_q[LD_BYTE], lane_q);
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:  if (start) state_n = CHECK;
            CHECK: begin
                if (mis)                        state_n = DONE;
                else if (we_q && sv_q == SV_WORD) state_n = WR;
                else if (we_q || re_q)          state_n = RD;
                else                            state_n = DONE;
            end
            RD:    if (acked) state_n = we_q ? WR : DONE;
            WR:    if (acked) state_n = DONE;
            DONE:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            re_q      <= 1'b0;
            ld_q      <= '0;
            sv_q      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rdata     <= '0;
            align_err <= 1'b0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
        end else begin
            busy    <= (state_n == CHECK) || (state_n == RD) ||
                       (state_n == WR);
            done    <= (state_n == DONE);
            bus_req <= (state_n == RD) || (state_n == WR);
            bus_we  <= (state_n == WR);
            if (accept) begin
                lane_q    <= addr[1:0];
                wdata_q   <= wdata;
                we_q      <= mem_write;
                re_q      <= mem_read;
                ld_q      <= load_option;
                sv_q      <= save_option;
                bus_addr  <= {addr[31:2], 2'b00};
                align_err <= 1'b0;
            end
            if (state == CHECK)
                align_err <= mis;
            // RMW merge uses the read word while it is still on the bus
            if (state_n == WR && state != WR)
                bus_wdata <= st_word;
            if (state == RD && acked && !we_q)
                rdata <= ld_word;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a wait-state
// programmable memory responder.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        mem_write = 1'b0;
    logic        mem_read = 1'b0;
    logic [2:0]  load_option = '0;
    logic [1:0]  save_option = '0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        busy, done, align_err, bus_req, bus_we;
    logic [31:0] rdata, bus_addr, bus_wdata;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          t0;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] mem [logic [29:0]];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          rd_waits = 0;
    int          wr_waits = 0;
    int          wcnt = 0;
    int          req_cnt = 0;
    int          addr_bad = 0;
    logic [31:0] exp_baddr = '0;

    mem_access_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .mem_write   (mem_write),
        .mem_read    (mem_read),
        .load_option (load_option),
        .save_option (save_option),
        .addr        (addr),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .rdata       (rdata),
        .align_err   (align_err),
        .bus_req     (bus_req),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_ack     (bus_ack),
        .bus_rdata   (bus_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Memory responder: commit on the edge, drive ack on the falling edge
    initial forever begin
        @(posedge clk);
        if (bus_req && bus_ack) begin
            if (bus_we) mem[bus_addr[31:2]] = bus_wdata;
            wcnt = 0;
        end
        @(negedge clk);
        bus_ack = 1'b0;
        if (!bus_req) begin
            wcnt = 0;
        end else begin
            req_cnt++;
            if (bus_addr !== exp_baddr) addr_bad++;
            if (wcnt >= (bus_we ? wr_waits : rd_waits)) begin
                bus_ack   = 1'b1;
                bus_rdata = mem.exists(bus_addr[31:2]) ?
                            mem[bus_addr[31:2]] : 32'h0;
            end else begin
                wcnt++;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (done) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected none");
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check({e.name, "_rdata"}, rdata, e.rdata);
                check({e.name, "_align_err"}, 32'(align_err), 32'(e.err));
                check({e.name, "_latency"}, cyc - e.t0, e.lat);
            end
        end
    end

    task automatic do_op(
        input string       nm,
        input logic        we,
        input logic        re,
        input logic [2:0]  ld,
        input logic [1:0]  sv,
        input logic [31:0] a,
        input logic [31:0] wd,
        input int          rw,
        input int          ww,
        input logic [31:0] exp_rd,
        input logic        err,
        input int          lat,
        input int          nreq,
        input logic        mid
    );
        bit got;
        @(negedge clk);
        rd_waits  = rw;
        wr_waits  = ww;
        req_cnt   = 0;
        addr_bad  = 0;
        exp_baddr = {a[31:2], 2'b00};
        sbq.push_back('{nm, exp_rd, err, lat, cyc});
        start       = 1'b1;
        mem_write   = we;
        mem_read    = re;
        load_option = ld;
        save_option = sv;
        addr        = a;
        wdata       = wd;
        @(negedge clk);
        start     = 1'b0;
        mem_write = 1'b0;
        mem_read  = 1'b0;
        addr      = 32'hFFFF_FFFF;
        wdata     = 32'h5A5A_5A5A;
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            start = mid && (i == 1);
            if (start) begin
                check({nm, "_busy"}, 32'(busy), 32'd1);
                mem_write   = 1'b1;
                save_option = 2'b01;
                addr        = 32'h6001;
                wdata       = 32'hFFFF_FFFF;
            end
            if (done) got = 1'b1;
            else @(negedge clk);
        end
        start     = 1'b0;
        mem_write = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done expected done", nm);
            sbq.delete();
        end
        check({nm, "_req_cycles"}, req_cnt, nreq);
        check({nm, "_addr_stable"}, addr_bad, 0);
    endtask

    initial begin
        bit got;
        mem[30'h400]  = 32'h80FF_1234;
        mem[30'h800]  = 32'h8001_5555;
        mem[30'hC00]  = 32'h1122_3344;
        mem[30'h1000] = 32'h0BAD_F00D;
        mem[30'h1400] = 32'hDEAD_BEEF;
        mem[30'h1800] = 32'h55AA_55AA;
        mem[30'h1C00] = 32'hAAAA_5555;

        repeat (3) @(negedge clk);
        check("reset_ctrl", 32'({busy, done, align_err, bus_req, bus_we}), 0);
        check("reset_rdata", rdata, 0);
        check("reset_bus_addr", bus_addr, 0);
        check("reset_bus_wdata", bus_wdata, 0);
        rst_n = 1'b1;

        do_op("lb", 0, 1, 3'b101, 2'b00, 32'h1003, 0, 0, 0,
              32'hFFFF_FF80, 0, 3, 1, 0);
        do_op("lbu", 0, 1, 3'b001, 2'b00, 32'h1003, 0, 0, 0,
              32'h0000_0080, 0, 3, 1, 0);
        do_op("lh", 0, 1, 3'b111, 2'b00, 32'h2002, 0, 0, 0,
              32'hFFFF_8001, 0, 3, 1, 0);
        do_op("lhu", 0, 1, 3'b011, 2'b00, 32'h2002, 0, 0, 0,
              32'h0000_8001, 0, 3, 1, 0);
        do_op("sb", 1, 0, 3'b000, 2'b01, 32'h3001, 32'h0000_00AB, 0, 0,
              32'h0000_8001, 0, 4, 2, 0);
        check("sb_mem", mem[30'hC00], 32'h1122_AB44);
        do_op("sh", 1, 0, 3'b000, 2'b10, 32'h3002, 32'h1234_CAFE, 0, 0,
              32'h0000_8001, 0, 4, 2, 0);
        check("sh_mem", mem[30'hC00], 32'hCAFE_AB44);
        do_op("sw_mis", 1, 0, 3'b000, 2'b00, 32'h4002, 32'h1111_1111, 0, 0,
              32'h0000_8001, 1, 2, 0, 0);
        check("sw_mis_mem", mem[30'h1000], 32'h0BAD_F00D);
        do_op("lh_mis", 0, 1, 3'b111, 2'b00, 32'h2001, 0, 0, 0,
              32'h0000_8001, 1, 2, 0, 0);
        do_op("noop", 0, 0, 3'b000, 2'b00, 32'h1000, 0, 0, 0,
              32'h0000_8001, 0, 2, 0, 0);
        do_op("lw_wait", 0, 1, 3'b000, 2'b00, 32'h5000, 0, 3, 0,
              32'hDEAD_BEEF, 0, 6, 4, 1);
        check("ignored_start_mem", mem[30'h1800], 32'h55AA_55AA);

        @(negedge clk);
        rd_waits  = 0;
        wr_waits  = 20;
        req_cnt   = 0;
        exp_baddr = 32'h7000;
        start       = 1'b1;
        mem_write   = 1'b1;
        save_option = 2'b10;
        addr        = 32'h7002;
        wdata       = 32'h0000_BEEF;
        @(negedge clk);
        start     = 1'b0;
        mem_write = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (bus_req && bus_we) got = 1'b1;
            else @(negedge clk);
        end
        check("rst_reached_wr", 32'(got), 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_bus_req", 32'(bus_req), 0);
        check("rst_busy_we", 32'({busy, bus_we, done}), 0);
        check("rst_rdata", rdata, 0);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_mem", mem[30'h1C00], 32'hAAAA_5555);

        do_op("sw_after_rst", 1, 0, 3'b000, 2'b00, 32'h7000,
              32'h0123_4567, 0, 0, 32'h0, 0, 3, 1, 0);
        check("sw_after_rst_mem", mem[30'h1C00], 32'h0123_4567);

        repeat (6) @(negedge clk);
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL pending_ops: got %0d expected 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store unit that executes the memory operation selected by the control unit's decode (MemWrite, MemtoReg, load_option, save_option, usigned) against a word-only data memory bus. It sits in the MEM stage of the multi-cycle CPU. It takes one start pulse per instruction and performs byte-lane extraction with sign/zero extension for loads. Sub-word stores are done as read-modify-write. It reports completion with a one-cycle done pulse.

## Interface
- No parameters; address and data are fixed at 32 bits.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- mem_write  in  1  store request (CU MemWrite).
- mem_read  in  1  load request (CU MemtoReg).
- load_option  in  3  CU encoding, decoded by bit:
  - bit0=0: word.
  - bit0=1, bit1=0: byte.
  - bit1=1: half.
  - bit2=1: sign-extend.
- save_option  in  2  01 = sb, 10 = sh, 00 = sw.
- addr  in  32  byte address; sampled with start.
- wdata  in  32  store data, right-aligned; sampled with start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle completion pulse.
- rdata  out  32  extended load result; valid with done and held until the next done.
- align_err  out  1  misaligned access flag; valid with done and held until the next accepted start.
- bus_req  out  1  memory transfer request.
- bus_we  out  1  write strobe for the current transfer.
- bus_addr  out  32  word address {addr[31:2], 2'b00}.
- bus_wdata  out  32  full word to write.
- bus_ack  in  1  transfer completes in any cycle where bus_req && bus_ack.
- bus_rdata  in  32  read word; valid in the ack cycle.

## Operation
- FSM states: IDLE, CHECK, RD, WR, DONE.
- IDLE: start latches addr, wdata, mem_write, mem_read, load_option and save_option, then moves to CHECK.
- CHECK: takes one cycle and selects the next state in this priority order:
  - misaligned → DONE with align_err=1 and no bus traffic. Misaligned means half with addr[0]=1, or word with addr[1:0]≠0.
  - mem_write with save_option 00 → WR.
  - mem_write with sub-word save_option → RD, then WR (read-modify-write).
  - mem_read → RD.
  - neither → DONE with no bus traffic.
  - mem_write has priority if both mem_write and mem_read are set.
- RD: bus_req=1, bus_we=0. On ack, capture bus_rdata. Go to WR if the operation is a store, otherwise DONE.
- WR: bus_req=1, bus_we=1. bus_wdata depends on store size:
  - sw: wdata.
  - sb: the captured word with byte lane addr[1:0] replaced by wdata[7:0].
  - sh: the captured word with half lane addr[1] replaced by wdata[15:0].
  - On ack, go to DONE.
- DONE: done=1 for one cycle; rdata updates on load completion only. Return to IDLE.
- Byte lane numbering is little-endian: lane 0 is bits [7:0].
- start outside IDLE is ignored; it is neither queued nor able to corrupt latched operands.
- Reset values:
  - FSM returns to IDLE.
  - busy, done, align_err, bus_req, bus_we = 0.
  - rdata, bus_addr, bus_wdata = 0.
- Reset mid-transfer drops bus_req immediately. The partial RMW is abandoned; the memory word is unchanged unless the write was already acked.

## Timing
- All outputs are registered; there is no combinational path from start or bus_ack to any output.
- bus_addr, bus_we and bus_wdata are stable from the rise of bus_req through the ack cycle.
- Latency with zero-wait ack, start in cycle 0:
  - load: CHECK in cycle 1, RD in cycle 2, done in cycle 3.
  - sw: WR in cycle 2, done in cycle 3.
  - sb/sh: RD in cycle 2, WR in cycle 3, done in cycle 4.
  - misaligned or no-op: done in cycle 2.
- Between RD ack and WR, bus_req stays high; bus_we rises and bus_wdata is updated in the same edge.
- Wait states are unbounded; the FSM has no timeout.
- A new start is accepted in the cycle after done, i.e. back-to-back with one IDLE cycle.

## Structure
- mem_pkg holds shared definitions:
  - state enum.
  - load_option field positions (LD_BYTE = bit0, LD_HALF = bit1, LD_SIGN = bit2).
  - save_option codes SV_WORD = 2'b00, SV_BYTE = 2'b01, SV_HALF = 2'b10.
- Sub-module lane_align (combinational) provides:
  - load extract: word, addr[1:0], load_option → 32-bit extended value.
  - store merge: old word, wdata, addr[1:0], save_option → new word.
- The FSM, operand latches and bus registers live in mem_access_unit.

## Test plan
- lb at 0x1003, memory word 0x80FF_1234, zero-wait ack → done at cycle 3 with rdata = 0xFFFF_FF80; lbu at the same address → 0x0000_0080.
- lh at 0x2002, memory word 0x8001_5555 → rdata = 0xFFFF_8001; lhu at the same address → 0x0000_8001.
- sb at 0x3001 with wdata 0x0000_00AB, memory word 0x1122_3344 → RD then WR; memory becomes 0x1122_AB44; done at cycle 4.
- sw at 0x4002 → align_err = 1 and done at cycle 2; bus_req never rises.
- lw at 0x5000 with 3 wait states → bus_addr stable for 4 cycles, done 1 cycle after ack; a start pulsed during busy is ignored.
- rst_n asserted during an RMW WR before ack → bus_req = 0 at once, memory unchanged, FSM in IDLE; next sw completes normally.
